// File: rtl/leaf_skid_stage_if.sv
// Handshake bundle for leaf_skid_stage: upstream valid/ready/data and downstream valid/ready/data.
// master drives words in and accepts words out; slave is the skid stage itself.
interface leaf_skid_stage_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );
endinterface

// File: rtl/leaf_skid_stage.sv
// Two-entry skid buffer (main + skid) with registered in_ready, plus a running
// transfer counter and modulo checksum of every word delivered downstream.
module leaf_skid_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  leaf_skid_stage_if.slave   bus,
  input  logic               clear,
  output logic [CNT_W-1:0]   xfer_cnt,
  output logic [CNT_W-1:0]   csum
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] csum_q, csum_d;
  logic             in_fire;
  logic             out_fire;

  function automatic logic [CNT_W-1:0] wrap_add(input logic [CNT_W-1:0] acc,
                                                input logic [WIDTH-1:0] word);
    logic [CNT_W-1:0] ext;
    ext = CNT_W'(word);
    return acc + ext;
  endfunction

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = (state_q != EMPTY) && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;

    if (out_fire) begin
      cnt_d  = cnt_q + CNT_W'(1);
      csum_d = wrap_add(csum_q, main_q);
    end

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = bus.in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = bus.in_data;
        end else if (in_fire) begin
          skid_d  = bus.in_data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain path exists
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (clear) begin
      state_d = EMPTY;
      cnt_d   = '0;
      csum_d  = '0;
    end

    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
      csum_q     <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_q;
  assign xfer_cnt      = cnt_q;
  assign csum          = csum_q;

endmodule

// File: tb/tb_leaf_skid_stage.sv
// Bench for leaf_skid_stage: directed vector table, wrap/reset sequences, and
// randomized traffic checked against a queue-based reference model.
module tb_leaf_skid_stage;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic clk;
  logic rst_n;
  logic clear;
  logic [CNT_W-1:0] xfer_cnt;
  logic [CNT_W-1:0] csum;

  leaf_skid_stage_if #(.WIDTH(WIDTH)) bus ();

  leaf_skid_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .clear    (clear),
    .xfer_cnt (xfer_cnt),
    .csum     (csum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] d;
    logic             ordy;
    logic             clr;
    logic             e_ir;
    logic             e_ov;
    logic             chk_od;
    logic [WIDTH-1:0] e_od;
    logic [CNT_W-1:0] e_cnt;
    logic [CNT_W-1:0] e_cs;
  } vec_t;

  vec_t tbl[16];

  // reference model state: words buffered in order, plus statistics
  logic [WIDTH-1:0] mq[$];
  logic [CNT_W-1:0] m_cnt;
  logic [CNT_W-1:0] m_cs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic clr);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    clear         = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mcycle(input logic iv, input logic [WIDTH-1:0] d, input logic ordy, input logic clr);
    bit in_f;
    bit out_f;
    in_f  = iv && (mq.size() < 2);
    out_f = ordy && (mq.size() > 0);
    drive(iv, d, ordy, clr);
    tick();
    if (clr) begin
      mq.delete();
      m_cnt = '0;
      m_cs  = '0;
    end else begin
      if (out_f) begin
        m_cnt = m_cnt + 1'b1;
        m_cs  = m_cs + CNT_W'(mq[0]);
        void'(mq.pop_front());
      end
      if (in_f) mq.push_back(d);
    end
    chk("rnd_in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
    chk("rnd_out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("rnd_out_data", 32'(bus.out_data), 32'(mq[0]));
    chk("rnd_xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
    chk("rnd_csum", 32'(csum), 32'(m_cs));
  endtask

  initial begin
    int stall;

    tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 16'd0, 16'h0000};
    tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 16'd1, 16'h0011};
    tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 16'd2, 16'h0033};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd3, 16'h0066};
    tbl[4]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 16'd3, 16'h0066};
    tbl[5]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 16'd3, 16'h0066};
    tbl[6]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 16'd3, 16'h0066};
    tbl[7]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 16'd4, 16'h0107};
    tbl[8]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, 16'd5, 16'h01A9};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd6, 16'h024C};
    tbl[10] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 16'd6, 16'h024C};
    tbl[11] = '{1'b1, 8'h06, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h06, 16'd7, 16'h0251};
    tbl[12] = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h06, 16'd7, 16'h0251};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0, 16'h0000};
    tbl[14] = '{1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0, 16'h0000};
    tbl[15] = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0, 16'h0000};

    // reset with clear and handshakes active: reset must win
    rst_n = 1'b0;
    drive(1'b1, 8'h5A, 1'b1, 1'b1);
    tick();
    tick();
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_data", 32'(bus.out_data), 32'd0);
    chk("reset_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("reset_csum", 32'(csum), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].clr);
      tick();
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].chk_od) chk($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].e_od));
      chk($sformatf("vec%0d_xfer_cnt", i), 32'(xfer_cnt), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_csum", i), 32'(csum), 32'(tbl[i].e_cs));
    end

    // counter/checksum wrap: stream 0xFF words with out_ready held high
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    stall = 0;
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 8'hFF, 1'b1, 1'b0);
      tick();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) stall++;
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    chk("wrap257_xfer_cnt", 32'(xfer_cnt), 32'd257);
    chk("wrap257_csum", 32'(csum), 32'h0000FFFF);
    chk("wrap257_out_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 65536 - 257; i++) begin
      drive(1'b1, 8'hFF, 1'b1, 1'b0);
      tick();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) stall++;
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    chk("stream_stall_cycles", 32'(stall), 32'd0);
    chk("wrap65536_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("wrap65536_csum", 32'(csum), 32'd0);

    // reset while FULL drops both buffered words
    drive(1'b1, 8'h31, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h32, 1'b0, 1'b0);
    tick();
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    tick();
    rst_n = 1'b1;
    chk("rstfull_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rstfull_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rstfull_out_data", 32'(bus.out_data), 32'd0);
    chk("rstfull_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("rstfull_csum", 32'(csum), 32'd0);
    drive(1'b1, 8'h7E, 1'b0, 1'b0);
    tick();
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_out_data", 32'(bus.out_data), 32'h7E);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    chk("post_rst_xfer_cnt", 32'(xfer_cnt), 32'd1);
    chk("post_rst_csum", 32'(csum), 32'h7E);
    chk("post_rst_drained", 32'(bus.out_valid), 32'd0);

    // randomized traffic against the queue model
    mq.delete();
    m_cnt = 16'd1;
    m_cs  = 16'h007E;
    for (int i = 0; i < 2000; i++) begin
      logic iv;
      logic ordy;
      logic clr;
      logic [WIDTH-1:0] d;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      clr  = ($urandom_range(0, 63) == 0);
      d    = WIDTH'($urandom);
      mcycle(iv, d, ordy, clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
